midi_poly_decoder: RTL and testbench

//  Parametrised MIDI front end: oversampled serial receive, running-status parsing, N-voice note tracking.

---
 rtl/midi_poly_decoder_pkg.sv | 36 +++
 rtl/midi_uart_rx.sv | 102 ++++++++++
 rtl/midi_poly_decoder.sv | 144 ++++++++++++++
 tb/tb_midi_poly_decoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_poly_decoder_pkg.sv
// ============================================================================
// Module  : midi_poly_decoder_pkg
// Brief   : MIDI status constants, RX state encoding and message-length helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package midi_poly_decoder_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PBEND    = 4'hE;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'h7B;
  localparam logic [7:0] RT_MIN           = 8'hF8;
  localparam logic [7:0] SYS_MIN          = 8'hF0;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Program change and channel aftertouch carry a single data byte
  function automatic logic is_one_data(input logic [7:0] status);
    return (status[7:4] == PROG) || (status[7:4] == CH_AT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/midi_uart_rx.sv
// ============================================================================
// Module  : midi_uart_rx
// Brief   : Synchronised, oversampled 8N1 receiver for the MIDI line
// Revision: 1.0
// ============================================================================
`default_nettype none

module midi_uart_rx
  import midi_poly_decoder_pkg::*;
#(
  parameter int BIT_TICKS = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_err
);

  localparam int CW = $clog2(BIT_TICKS);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(BIT_TICKS / 2 - 1);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(BIT_TICKS - 1);

  logic            r_sync1, r_sync2;
  rx_state_t       r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [2:0]      r_bit, w_bit_n;
  logic [7:0]      r_shift, w_shift_n;
  logic            r_valid, w_valid_n;
  logic            r_ferr, w_ferr_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= midi_in;
      r_sync2 <= r_sync1;
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_valid <= w_valid_n;
      r_ferr  <= w_ferr_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + CW'(1);
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_valid_n = 1'b0;
    w_ferr_n  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_n = '0;
        if (!r_sync2) w_state_n = RX_START;
      end
      RX_START: begin
        // Mid-start-bit check rejects short glitches
        if (r_cnt == C_HALF_LAST) begin
          w_cnt_n   = '0;
          w_bit_n   = '0;
          w_state_n = r_sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_n   = '0;
          w_shift_n = {r_sync2, r_shift[7:1]};
          w_bit_n   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_n   = '0;
          w_valid_n = r_sync2;
          w_ferr_n  = ~r_sync2;
          w_state_n = RX_IDLE;
        end
      end
      default: w_state_n = RX_IDLE;
    endcase
  end

  // Shift register holds still through STOP/IDLE, so it is the byte output
  assign byte_valid  = r_valid;
  assign byte_data   = r_shift;
  assign framing_err = r_ferr;

endmodule

`default_nettype wire

// File: rtl/midi_poly_decoder.sv
// ============================================================================
// Module  : midi_poly_decoder
// Brief   : MIDI receive, running-status parser and N-voice note table
// Revision: 1.0
// ============================================================================
`default_nettype none

module midi_poly_decoder
  import midi_poly_decoder_pkg::*;
#(
  parameter int BIT_TICKS  = 128,
  parameter int NUM_VOICES = 4,
  parameter int CHANNEL    = 0,
  parameter bit OMNI       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    midi_in,
  output logic                    msg_valid,
  output logic [7:0]              msg_status,
  output logic [6:0]              msg_data1,
  output logic [6:0]              msg_data2,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic                    framing_err,
  output logic                    voice_ovf
);

  logic       w_byte_valid;
  logic [7:0] w_byte;

  midi_uart_rx #(
    .BIT_TICKS (BIT_TICKS)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .midi_in     (midi_in),
    .byte_valid  (w_byte_valid),
    .byte_data   (w_byte),
    .framing_err (framing_err)
  );

  logic [7:0] r_status;
  logic       r_have1;
  logic [6:0] r_d1;

  // r_status == 0 means no running status (bit 7 clear)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_status   <= '0;
      r_have1    <= 1'b0;
      r_d1       <= '0;
      msg_valid  <= 1'b0;
      msg_status <= '0;
      msg_data1  <= '0;
      msg_data2  <= '0;
    end else begin
      msg_valid <= 1'b0;
      if (w_byte_valid && (w_byte < RT_MIN)) begin
        if (w_byte >= SYS_MIN) begin
          r_status <= '0;
        end else if (w_byte[7]) begin
          r_status <= w_byte;
          r_have1  <= 1'b0;
        end else if (r_status[7]) begin
          if (is_one_data(r_status)) begin
            msg_valid  <= 1'b1;
            msg_status <= r_status;
            msg_data1  <= w_byte[6:0];
            msg_data2  <= '0;
          end else if (!r_have1) begin
            r_d1    <= w_byte[6:0];
            r_have1 <= 1'b1;
          end else begin
            msg_valid  <= 1'b1;
            msg_status <= r_status;
            msg_data1  <= r_d1;
            msg_data2  <= w_byte[6:0];
            r_have1    <= 1'b0;
          end
        end
      end
    end
  end

  logic                  w_apply, w_note_on, w_note_off, w_all_off, w_hit;
  logic [3:0]            w_hi;
  logic [NUM_VOICES-1:0] w_match, w_free, w_alloc, w_set, w_upd, w_clr;

  assign w_hi       = msg_status[7:4];
  assign w_apply    = msg_valid && (OMNI || (msg_status[3:0] == 4'(CHANNEL)));
  assign w_note_on  = w_apply && (w_hi == NOTE_ON) && (msg_data2 != 7'd0);
  assign w_note_off = w_apply && ((w_hi == NOTE_OFF) ||
                                  ((w_hi == NOTE_ON) && (msg_data2 == 7'd0)));
  assign w_all_off  = w_apply && (w_hi == CC) && (msg_data1 == CC_ALL_NOTES_OFF);

  assign w_hit   = |w_match;
  assign w_free  = ~voice_active;
  // Isolate the lowest set bit of the free mask
  assign w_alloc = w_free & (~w_free + NUM_VOICES'(1));
  assign w_set   = (w_note_on && !w_hit) ? w_alloc : '0;
  assign w_upd   = w_note_on ? w_match : '0;
  assign w_clr   = w_all_off ? '1 : (w_note_off ? w_match : '0);

  generate
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
      logic       r_act;
      logic [6:0] r_note;
      logic [6:0] r_vel;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_act  <= 1'b0;
          r_note <= '0;
          r_vel  <= '0;
        end else if (w_clr[i]) begin
          r_act  <= 1'b0;
          r_note <= '0;
          r_vel  <= '0;
        end else if (w_set[i]) begin
          r_act  <= 1'b1;
          r_note <= msg_data1;
          r_vel  <= msg_data2;
        end else if (w_upd[i]) begin
          r_vel  <= msg_data2;
        end
      end

      assign w_match[i]          = r_act && (r_note == msg_data1);
      assign voice_active[i]     = r_act;
      assign voice_note[7*i +: 7] = r_note;
      assign voice_vel[7*i +: 7]  = r_vel;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) voice_ovf <= 1'b0;
    else        voice_ovf <= w_note_on && !w_hit && !(|w_free);
  end

endmodule

`default_nettype wire

// File: tb/tb_midi_poly_decoder.sv
// ============================================================================
// Module  : tb_midi_poly_decoder
// Brief   : Scoreboard bench, OMNI=0 and OMNI=1 decoders on one MIDI line
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_midi_poly_decoder;

  localparam int BT = 8;
  localparam int NV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic midi = 1'b1;

  logic [1:0]            mv, fe, vo;
  logic [1:0][7:0]       ms;
  logic [1:0][6:0]       md1, md2;
  logic [1:0][NV-1:0]    va;
  logic [1:0][7*NV-1:0]  vn, vv;

  always #5 clk = ~clk;

  midi_poly_decoder #(.BIT_TICKS(BT), .NUM_VOICES(NV), .CHANNEL(0), .OMNI(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .midi_in(midi),
    .msg_valid(mv[0]), .msg_status(ms[0]), .msg_data1(md1[0]), .msg_data2(md2[0]),
    .voice_active(va[0]), .voice_note(vn[0]), .voice_vel(vv[0]),
    .framing_err(fe[0]), .voice_ovf(vo[0]));

  midi_poly_decoder #(.BIT_TICKS(BT), .NUM_VOICES(NV), .CHANNEL(0), .OMNI(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .midi_in(midi),
    .msg_valid(mv[1]), .msg_status(ms[1]), .msg_data1(md1[1]), .msg_data2(md2[1]),
    .voice_active(va[1]), .voice_note(vn[1]), .voice_vel(vv[1]),
    .framing_err(fe[1]), .voice_ovf(vo[1]));

  typedef struct packed {
    logic [7:0]      st;
    logic [6:0]      d1;
    logic [6:0]      d2;
    logic [1:0][NV-1:0]   act;
    logic [1:0][7*NV-1:0] note;
    logic [1:0][7*NV-1:0] vel;
    logic [1:0]      ovf;
  } exp_t;

  exp_t q[$];
  int errors = 0, checks = 0;
  int n_msg = 0, n_ovf0 = 0, n_ovf1 = 0, n_ferr = 0;
  int exp_msg = 0, exp_ovf0 = 0, exp_ovf1 = 0, exp_ferr = 0;

  // Reference model: parser context plus two note tables (channel 0 only / omni)
  logic [7:0] m_st = 8'h00;
  bit         m_have1 = 1'b0;
  logic [6:0] m_d1 = 7'h00;
  bit         m_act  [2][NV];
  logic [6:0] m_note [2][NV];
  logic [6:0] m_vel  [2][NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 8'h00;
    m_have1 = 1'b0;
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < NV; i++) begin
        m_act[t][i] = 1'b0; m_note[t][i] = '0; m_vel[t][i] = '0;
      end
  endtask

  task automatic apply(input int t, input logic [7:0] st, input logic [6:0] d1,
                       input logic [6:0] d2, output bit ovf);
    int found, free;
    ovf = 1'b0;
    found = -1;
    for (int i = 0; i < NV; i++)
      if (m_act[t][i] && m_note[t][i] == d1) found = i;
    if (st[7:4] == 4'h9 && d2 != 0) begin
      if (found >= 0) m_vel[t][found] = d2;
      else begin
        free = -1;
        for (int i = NV - 1; i >= 0; i--) if (!m_act[t][i]) free = i;
        if (free >= 0) begin
          m_act[t][free] = 1'b1; m_note[t][free] = d1; m_vel[t][free] = d2;
        end else ovf = 1'b1;
      end
    end else if (st[7:4] == 4'h8 || st[7:4] == 4'h9) begin
      if (found >= 0) m_act[t][found] = 1'b0;
    end else if (st[7:4] == 4'hB && d1 == 7'h7B) begin
      for (int i = 0; i < NV; i++) m_act[t][i] = 1'b0;
    end
  endtask

  task automatic complete(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2);
    exp_t e;
    bit   ovf;
    e = '0;
    e.st = st; e.d1 = d1; e.d2 = d2;
    for (int t = 0; t < 2; t++) begin
      ovf = 1'b0;
      if (t == 1 || st[3:0] == 4'h0) apply(t, st, d1, d2, ovf);
      e.ovf[t] = ovf;
      for (int i = 0; i < NV; i++) begin
        e.act[t][i]       = m_act[t][i];
        e.note[t][7*i +: 7] = m_note[t][i];
        e.vel[t][7*i +: 7]  = m_vel[t][i];
      end
    end
    exp_ovf0 += int'(e.ovf[0]);
    exp_ovf1 += int'(e.ovf[1]);
    exp_msg++;
    q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) m_st = 8'h00;
    else if (b[7]) begin m_st = b; m_have1 = 1'b0; end
    else if (m_st != 8'h00) begin
      if (m_st[7:4] == 4'hC || m_st[7:4] == 4'hD) complete(m_st, b[6:0], 7'h00);
      else if (!m_have1) begin m_d1 = b[6:0]; m_have1 = 1'b1; end
      else begin complete(m_st, m_d1, b[6:0]); m_have1 = 1'b0; end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
    if (bad_stop) exp_ferr++;
    else          model_byte(b);
    midi = 1'b0; tick(BT);
    for (int i = 0; i < 8; i++) begin midi = b[i]; tick(BT); end
    midi = ~bad_stop; tick(BT);
    midi = 1'b1;
    tick($urandom_range(0, 12));
    if (bad_stop) tick(100);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a); send_byte(b); send_byte(c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick(4);
    check("reset_msg_valid", 32'(mv), 32'd0);
    check("reset_fields0", {ms[0], md1[0], md2[0]}, 32'd0);
    check("reset_active", 32'(va), 32'd0);
    check("reset_notes", 32'(|{vn, vv}), 32'd0);
    check("reset_strobes", 32'({fe, vo}), 32'd0);
    rst_n = 1'b1;
    tick(3);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [3:0] his [9];
    his = '{4'h8, 4'h9, 4'h9, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    r = $urandom_range(0, 99);
    if (r < 3)  return 8'hF8 + 8'($urandom_range(0, 7));
    if (r < 5)  return 8'hF0 + 8'($urandom_range(0, 7));
    if (r < 30) return {his[$urandom_range(0, 8)], 4'($urandom_range(0, 2))};
    if (r < 38) return 8'h7B;
    if (r < 50) return 8'h00;
    return 8'h3C + 8'($urandom_range(0, 5));
  endfunction

  // Monitor: pops one expectation per msg_valid, checks the table one cycle later
  initial begin : monitor
    exp_t cur;
    bit   pend;
    pend = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          for (int t = 0; t < 2; t++) begin
            check($sformatf("voice_active%0d", t), 32'(va[t]), 32'(cur.act[t]));
            check($sformatf("voice_ovf%0d", t), 32'(vo[t]), 32'(cur.ovf[t]));
            for (int i = 0; i < NV; i++)
              if (cur.act[t][i]) begin
                check($sformatf("voice_note%0d_%0d", t, i), 32'(vn[t][7*i +: 7]), 32'(cur.note[t][7*i +: 7]));
                check($sformatf("voice_vel%0d_%0d", t, i), 32'(vv[t][7*i +: 7]), 32'(cur.vel[t][7*i +: 7]));
              end
          end
          pend = 1'b0;
        end
        if (mv[0]) begin
          n_msg++;
          if (q.size() == 0) check("msg_unexpected", 32'd1, 32'd0);
          else begin
            cur = q.pop_front();
            for (int t = 0; t < 2; t++) begin
              check($sformatf("msg_valid%0d", t), 32'(mv[t]), 32'd1);
              check($sformatf("msg_fields%0d", t), {ms[t], md1[t], md2[t]}, {cur.st, cur.d1, cur.d2});
            end
            pend = 1'b1;
          end
        end else if (mv[1]) check("msg_valid_pair", 32'(mv[0]), 32'(mv[1]));
        if (vo[0]) n_ovf0++;
        if (vo[1]) n_ovf1++;
        if (fe[0]) n_ferr++;
      end
    end
  end

  initial begin : stim
    int ovf_base;
    model_reset();
    do_reset();

    // Single note-on
    send3(8'h90, 8'h3C, 8'h64);
    check("t1_active", 32'(va[0]), 32'h1);

    // Running status, note-off via velocity 0
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    send_byte(8'h40); send_byte(8'h50);
    send_byte(8'h3C); send_byte(8'h00);
    check("t2_active", 32'(va[0]), 32'h2);

    // Overflow on the fifth note, then velocity update of an existing note
    send3(8'hB0, 8'h7B, 8'h00);
    ovf_base = n_ovf0;
    send_byte(8'h90);
    for (int i = 0; i < 5; i++) begin send_byte(8'h3C + 8'(i)); send_byte(8'h10 + 8'(i)); end
    send_byte(8'h3C); send_byte(8'h7F);
    tick(3);
    check("t3_ovf_count", 32'(n_ovf0 - ovf_base), 32'd1);
    check("t3_slot0_vel", 32'(vv[0][6:0]), 32'h7F);

    // Embedded realtime, system-common clears running status
    send_byte(8'h80); send_byte(8'h3D); send_byte(8'h00);
    send_byte(8'h90); send_byte(8'h3D); send_byte(8'hF8); send_byte(8'h22);
    send3(8'hF0, 8'h3E, 8'h64);
    send_byte(8'hC0); send_byte(8'h05);

    // Framing error, start glitch, recovery
    send_byte(8'h90); send_byte(8'h41);
    send_byte(8'h64, 1'b1);
    midi = 1'b0; tick(2); midi = 1'b1; tick(40);
    send3(8'h80, 8'h3C, 8'h00);

    // Channel 1: only the omni decoder reacts
    send3(8'h91, 8'h3C, 8'h64);
    send3(8'hB1, 8'h7B, 8'h00);
    tick(3);
    check("t6_omni_cleared", 32'(va[1]), 32'h0);

    // Reset in the middle of a message discards it
    send_byte(8'h90); send_byte(8'h3C);
    tick(5);
    do_reset();
    send_byte(8'h64);

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        midi = 1'b0; tick($urandom_range(1, 2)); midi = 1'b1; tick(20);
      end
      send_byte(rand_byte());
    end

    tick(50);
    check("queue_drained", 32'(q.size()), 32'd0);
    check("msg_count", 32'(n_msg), 32'(exp_msg));
    check("ovf_count0", 32'(n_ovf0), 32'(exp_ovf0));
    check("ovf_count1", 32'(n_ovf1), 32'(exp_ovf1));
    check("ferr_count", 32'(n_ferr), 32'(exp_ferr));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
